shift_issue_pipe: RTL

- Two-stage handshaked front-end/back-end for the datapath shift unit.
- Stage A decodes the R-type shift funct, selects the shift amount and latches the operands. This stage feeds the combinational right shifter. Left shifts are done by bit-reversing around a logical right shift.
- Stage B registers the result and presents it to writeback with valid/ready flow control.
- Sits between register-read/decode and writeback, alongside the ALU.

---
 rtl/shift_issue_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/shift_issue_pipe.sv
// Two-stage handshaked shift unit: stage A decodes the R-type shift funct and
// latches operands, stage B registers the shifted result for writeback.
module shift_issue_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  typedef enum logic [5:0] {
    F_SLL  = 6'b000000,
    F_SRL  = 6'b000010,
    F_SRA  = 6'b000011,
    F_SLLV = 6'b000100,
    F_SRLV = 6'b000110,
    F_SRAV = 6'b000111
  } funct_e;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) bit_rev[i] = v[WIDTH-1-i];
  endfunction

  logic             a_valid_q, a_valid_d;
  logic [SHW-1:0]   a_amt_q, a_amt_d;
  logic             a_left_q, a_left_d;
  logic             a_arith_q, a_arith_d;
  logic             a_illegal_q, a_illegal_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] b_result_q, b_result_d;
  logic             b_illegal_q, b_illegal_d;

  logic             b_adv, a_adv, in_fire, out_fire;
  logic [SHW-1:0]   dec_amt;
  logic             dec_left, dec_arith, dec_illegal;
  logic [WIDTH-1:0] shift_src, shift_out, sh_result;
  logic [2*WIDTH-1:0] shift_ext;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec_amt     = shamt;
    dec_left    = 1'b0;
    dec_arith   = 1'b0;
    dec_illegal = 1'b0;
    case (funct)
      F_SLL:  dec_left = 1'b1;
      F_SRL:  ;
      F_SRA:  dec_arith = 1'b1;
      F_SLLV: begin dec_amt = rs_val[SHW-1:0]; dec_left = 1'b1; end
      F_SRLV: dec_amt = rs_val[SHW-1:0];
      F_SRAV: begin dec_amt = rs_val[SHW-1:0]; dec_arith = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  // One right shifter serves both directions; left shifts are mirrored around it.
  always_comb begin
    shift_src = a_left_q ? bit_rev(a_data_q) : a_data_q;
    shift_ext = {{WIDTH{a_arith_q & shift_src[WIDTH-1]}}, shift_src} >> a_amt_q;
    shift_out = shift_ext[WIDTH-1:0];
    sh_result = a_illegal_q ? '0 : (a_left_q ? bit_rev(shift_out) : shift_out);
  end

  always_comb begin
    b_adv    = !b_valid_q || out_ready;
    a_adv    = a_valid_q && b_adv;
    in_ready = !a_valid_q || b_adv;
    in_fire  = in_valid && in_ready;
    out_fire = b_valid_q && out_ready;

    a_valid_d   = a_valid_q;
    a_amt_d     = a_amt_q;
    a_left_d    = a_left_q;
    a_arith_d   = a_arith_q;
    a_illegal_d = a_illegal_q;
    a_data_d    = a_data_q;
    b_valid_d   = b_valid_q;
    b_result_d  = b_result_q;
    b_illegal_d = b_illegal_q;

    if (flush)        a_valid_d = 1'b0;
    else if (in_fire) a_valid_d = 1'b1;
    else if (a_adv)   a_valid_d = 1'b0;

    if (in_fire && !flush) begin
      a_amt_d     = dec_amt;
      a_left_d    = dec_left;
      a_arith_d   = dec_arith;
      a_illegal_d = dec_illegal;
      a_data_d    = rt_val;
    end

    // Flush wins over the output handshake; result/illegal keep their last values.
    if (flush)         b_valid_d = 1'b0;
    else if (a_adv)    b_valid_d = 1'b1;
    else if (out_fire) b_valid_d = 1'b0;

    if (a_adv && !flush) begin
      b_result_d  = sh_result;
      b_illegal_d = a_illegal_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_amt_q     <= '0;
      a_left_q    <= 1'b0;
      a_arith_q   <= 1'b0;
      a_illegal_q <= 1'b0;
      a_data_q    <= '0;
      b_valid_q   <= 1'b0;
      b_result_q  <= '0;
      b_illegal_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_amt_q     <= a_amt_d;
      a_left_q    <= a_left_d;
      a_arith_q   <= a_arith_d;
      a_illegal_q <= a_illegal_d;
      a_data_q    <= a_data_d;
      b_valid_q   <= b_valid_d;
      b_result_q  <= b_result_d;
      b_illegal_q <= b_illegal_d;
    end
  end

  assign out_valid = b_valid_q;
  assign result    = b_result_q;
  assign illegal   = b_illegal_q;

endmodule
